// File: rtl/q_episode_scheduler.sv
// q_episode_scheduler
//
// Episode-level sequencer for the Q-learning grid agent. A run is started by
// i_run and consists of NUM_EPISODES episodes. Each episode:
//   1. pulses o_start with the start state,
//   2. requests one step at a time with an epsilon-greedy explore decision,
//   3. ends on reaching GOAL_STATE or after MAX_STEPS steps.
// Epsilon decays by EPS_DEC after every completed episode and never drops
// below EPS_MIN. An 8-bit Fibonacci LFSR (taps 8,6,5,4) free-runs every cycle
// and supplies both the explore draw and the random action.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_run           one-cycle pulse; starts a run from IDLE or DONE
//   i_abort         forces IDLE next cycle from any state, highest priority
//   i_first_st      start state, sampled whenever an episode starts
//   i_step_valid    step finished by the step controller (used only in WAIT)
//   i_next_st       resulting state, qualified by i_step_valid
//   o_start         one-cycle pulse to the step controller
//   o_first_st      state presented with o_start
//   o_step_req      one-cycle step request pulse
//   o_explore       1 = use o_rand_at, 0 = use greedy action
//   o_rand_at       random action, lfsr[ACTIONS_WIDTH-1:0]
//   o_episode_done  one-cycle pulse at episode end
//   o_goal_reached  1 = episode ended on goal, 0 = step limit
//   o_step_cnt      steps taken in the current episode
//   o_episode_cnt   completed episodes in this run
//   o_epsilon       current epsilon (out of 256)
//   o_busy          high in every state except IDLE and DONE
//   o_done          level, high in DONE
// All outputs are registered.

module q_episode_scheduler #(
    parameter int          STATES_WIDTH  = 5,
    parameter int          ACTIONS_WIDTH = 2,
    parameter int          GOAL_STATE    = 24,
    parameter int          MAX_STEPS     = 64,
    parameter int          NUM_EPISODES  = 100,
    parameter logic [7:0]  EPS_INIT      = 8'd230,
    parameter logic [7:0]  EPS_MIN       = 8'd13,
    parameter logic [7:0]  EPS_DEC       = 8'd2,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    input  logic                     i_abort,
    input  logic [STATES_WIDTH-1:0]  i_first_st,
    input  logic                     i_step_valid,
    input  logic [STATES_WIDTH-1:0]  i_next_st,
    output logic                     o_start,
    output logic [STATES_WIDTH-1:0]  o_first_st,
    output logic                     o_step_req,
    output logic                     o_explore,
    output logic [ACTIONS_WIDTH-1:0] o_rand_at,
    output logic                     o_episode_done,
    output logic                     o_goal_reached,
    output logic [7:0]               o_step_cnt,
    output logic [15:0]              o_episode_cnt,
    output logic [7:0]               o_epsilon,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [STATES_WIDTH-1:0] GOAL_ST = STATES_WIDTH'(GOAL_STATE);
    localparam logic [7:0]              MAX_ST  = 8'(MAX_STEPS);
    localparam logic [15:0]             NUM_EP  = 16'(NUM_EPISODES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STEP_REQ,
        WAIT,
        EVAL,
        EP_END,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              lfsr;
    logic [STATES_WIDTH-1:0] cur_st;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3). A nonzero seed keeps it
    // out of the all-zero lock-up state forever.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Epsilon decay with floor. The subtraction is done in 9 bits so a
    // borrow shows up in bit 8 instead of wrapping to a large value.
    function automatic logic [7:0] eps_decay(input logic [7:0] eps);
        logic [8:0] diff;
        diff = {1'b0, eps} - {1'b0, EPS_DEC};
        if (diff[8] || (diff[7:0] < EPS_MIN))
            return EPS_MIN;
        return diff[7:0];
    endfunction

    logic explore_now;
    logic goal_hit;
    logic limit_hit;

    assign explore_now = (lfsr < o_epsilon);
    assign goal_hit    = (cur_st == GOAL_ST);
    assign limit_hit   = (o_step_cnt == MAX_ST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= LFSR_SEED;
            cur_st         <= '0;
            o_start        <= 1'b0;
            o_first_st     <= '0;
            o_step_req     <= 1'b0;
            o_explore      <= 1'b0;
            o_rand_at      <= '0;
            o_episode_done <= 1'b0;
            o_goal_reached <= 1'b0;
            o_step_cnt     <= 8'd0;
            o_episode_cnt  <= 16'd0;
            o_epsilon      <= EPS_INIT;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);

            // Pulses are high for exactly one cycle after the transition
            // that raised them.
            o_start        <= 1'b0;
            o_step_req     <= 1'b0;
            o_episode_done <= 1'b0;

            if (i_abort) begin
                // Counters and epsilon are left alone; the next run clears them.
                state  <= IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (i_run) begin
                            state         <= START;
                            o_start       <= 1'b1;
                            o_first_st    <= i_first_st;
                            o_step_cnt    <= 8'd0;
                            o_episode_cnt <= 16'd0;
                            o_epsilon     <= EPS_INIT;
                            o_busy        <= 1'b1;
                            o_done        <= 1'b0;
                        end
                    end

                    START: begin
                        state      <= STEP_REQ;
                        o_step_req <= 1'b1;
                        o_explore  <= explore_now;
                        o_rand_at  <= lfsr[ACTIONS_WIDTH-1:0];
                    end

                    // The request pulse is already on the wire; a step result
                    // arriving now is too early and is dropped.
                    STEP_REQ: begin
                        state <= WAIT;
                    end

                    WAIT: begin
                        if (i_step_valid) begin
                            cur_st     <= i_next_st;
                            o_step_cnt <= o_step_cnt + 8'd1;
                            state      <= EVAL;
                        end
                    end

                    // Goal is tested first so a goal on the last allowed step
                    // still reports as a goal.
                    EVAL: begin
                        if (goal_hit || limit_hit) begin
                            state          <= EP_END;
                            o_episode_done <= 1'b1;
                            o_goal_reached <= goal_hit;
                            o_episode_cnt  <= o_episode_cnt + 16'd1;
                            o_epsilon      <= eps_decay(o_epsilon);
                        end else begin
                            state      <= STEP_REQ;
                            o_step_req <= 1'b1;
                            o_explore  <= explore_now;
                            o_rand_at  <= lfsr[ACTIONS_WIDTH-1:0];
                        end
                    end

                    // o_episode_cnt already holds the post-increment count here.
                    EP_END: begin
                        if (o_episode_cnt == NUM_EP) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state      <= START;
                            o_start    <= 1'b1;
                            o_first_st <= i_first_st;
                            o_step_cnt <= 8'd0;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_q_episode_scheduler.sv
// Directed bench for q_episode_scheduler. DUT built with MAX_STEPS = 4 and
// NUM_EPISODES = 120 so step-limit and epsilon-floor behaviour fit in a
// short run. Inputs change on the falling edge; outputs are sampled there.

module tb_q_episode_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic        i_abort;
    logic [4:0]  i_first_st;
    logic        i_step_valid;
    logic [4:0]  i_next_st;
    logic        o_start;
    logic [4:0]  o_first_st;
    logic        o_step_req;
    logic        o_explore;
    logic [1:0]  o_rand_at;
    logic        o_episode_done;
    logic        o_goal_reached;
    logic [7:0]  o_step_cnt;
    logic [15:0] o_episode_cnt;
    logic [7:0]  o_epsilon;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q_episode_scheduler #(
        .STATES_WIDTH (5),
        .ACTIONS_WIDTH(2),
        .GOAL_STATE   (24),
        .MAX_STEPS    (4),
        .NUM_EPISODES (120),
        .EPS_INIT     (8'd230),
        .EPS_MIN      (8'd13),
        .EPS_DEC      (8'd2),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (i_run),
        .i_abort       (i_abort),
        .i_first_st    (i_first_st),
        .i_step_valid  (i_step_valid),
        .i_next_st     (i_next_st),
        .o_start       (o_start),
        .o_first_st    (o_first_st),
        .o_step_req    (o_step_req),
        .o_explore     (o_explore),
        .o_rand_at     (o_rand_at),
        .o_episode_done(o_episode_done),
        .o_goal_reached(o_goal_reached),
        .o_step_cnt    (o_step_cnt),
        .o_episode_cnt (o_episode_cnt),
        .o_epsilon     (o_epsilon),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // Reference LFSR: taps 8,6,5,4. lfsr_prev holds the value the DUT saw at
    // the most recent rising edge, i.e. the one behind a fresh o_step_req.
    logic [7:0] m_lfsr;
    logic [7:0] lfsr_prev;

    function automatic logic [7:0] ref_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) begin
        lfsr_prev <= m_lfsr;
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= ref_next(m_lfsr);
    end

    // Epsilon expected after k completed episodes.
    function automatic logic [7:0] eps_after(input int k);
        int e;
        e = 230 - 2 * k;
        if (e < 13) e = 13;
        return 8'(e);
    endfunction

    // Pulse i_run; returns in the cycle o_start should be high.
    task automatic start_run();
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    task automatic do_abort();
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
    endtask

    // Called in the o_step_req cycle: answers in WAIT, returns two cycles
    // after the answer (step_req or episode_done cycle).
    task automatic step(input logic [4:0] nst);
        @(negedge clk);
        i_step_valid = 1'b1;
        i_next_st    = nst;
        @(negedge clk);
        i_step_valid = 1'b0;
        i_next_st    = 5'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_first_st = 5'd3;
        start_run();
        @(negedge clk);
        step(5'd5);                 // one step done, back in STEP_REQ
        @(negedge clk);             // WAIT
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", o_start); end
        checks++; if (o_step_req !== 1'b0) begin errors++; $display("FAIL rst_step_req got %b exp 0", o_step_req); end
        checks++; if (o_first_st !== 5'd0) begin errors++; $display("FAIL rst_first_st got %0d exp 0", o_first_st); end
        checks++; if (o_step_cnt !== 8'd0) begin errors++; $display("FAIL rst_step_cnt got %0d exp 0", o_step_cnt); end
        checks++; if (o_episode_cnt !== 16'd0) begin errors++; $display("FAIL rst_ep_cnt got %0d exp 0", o_episode_cnt); end
        checks++; if ({o_explore, o_rand_at, o_goal_reached, o_episode_done} !== 5'd0) begin errors++; $display("FAIL rst_misc got %b exp 00000", {o_explore, o_rand_at, o_goal_reached, o_episode_done}); end
        checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {o_busy, o_done}); end
        checks++; if (o_epsilon !== 8'd230) begin errors++; $display("FAIL rst_epsilon got %0d exp 230", o_epsilon); end
        checks++; if (dut.lfsr !== 8'hA5) begin errors++; $display("FAIL rst_lfsr got %h exp a5", dut.lfsr); end
        rst          = 1'b0;
        i_step_valid = 1'b1;
        i_next_st    = 5'd24;
        @(negedge clk);
        i_step_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({o_start, o_step_req, o_episode_done, o_busy} !== 4'b0) begin errors++; $display("FAIL rst_post_pulses cyc %0d got %b exp 0000", c, {o_start, o_step_req, o_episode_done, o_busy}); end
            @(negedge clk);
        end
        checks++; if (o_step_cnt !== 8'd0) begin errors++; $display("FAIL rst_post_step_cnt got %0d exp 0", o_step_cnt); end
    endtask

    task automatic test_goal_path();
        i_first_st = 5'd19;
        start_run();
        checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL goal_start got %b exp 1", o_start); end
        checks++; if (o_first_st !== 5'd19) begin errors++; $display("FAIL goal_first_st got %0d exp 19", o_first_st); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL goal_busy got %b exp 1", o_busy); end
        @(negedge clk);
        checks++; if (o_step_req !== 1'b1) begin errors++; $display("FAIL goal_step_req got %b exp 1", o_step_req); end
        step(5'd24);
        checks++; if (o_episode_done !== 1'b1) begin errors++; $display("FAIL goal_ep_done got %b exp 1", o_episode_done); end
        checks++; if (o_goal_reached !== 1'b1) begin errors++; $display("FAIL goal_reached got %b exp 1", o_goal_reached); end
        checks++; if (o_step_cnt !== 8'd1) begin errors++; $display("FAIL goal_step_cnt got %0d exp 1", o_step_cnt); end
        checks++; if (o_episode_cnt !== 16'd1) begin errors++; $display("FAIL goal_ep_cnt got %0d exp 1", o_episode_cnt); end
        checks++; if (o_epsilon !== 8'd228) begin errors++; $display("FAIL goal_epsilon got %0d exp 228", o_epsilon); end
        @(negedge clk);
        checks++; if ({o_start, o_episode_done} !== 2'b10) begin errors++; $display("FAIL goal_restart got %b exp 10", {o_start, o_episode_done}); end
        checks++; if (o_first_st !== 5'd19) begin errors++; $display("FAIL goal_restart_st got %0d exp 19", o_first_st); end
        do_abort();
    endtask

    task automatic test_step_limit();
        i_first_st = 5'd2;
        start_run();
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            step(5'd0);
            if (k < 4) begin
                checks++; if ({o_step_req, o_episode_done} !== 2'b10) begin errors++; $display("FAIL lim_mid step %0d got %b exp 10", k, {o_step_req, o_episode_done}); end
            end
        end
        checks++; if (o_episode_done !== 1'b1) begin errors++; $display("FAIL lim_ep_done got %b exp 1", o_episode_done); end
        checks++; if (o_goal_reached !== 1'b0) begin errors++; $display("FAIL lim_goal got %b exp 0", o_goal_reached); end
        checks++; if (o_step_cnt !== 8'd4) begin errors++; $display("FAIL lim_step_cnt got %0d exp 4", o_step_cnt); end
        @(negedge clk);
        checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL lim_restart got %b exp 1", o_start); end
        checks++; if (o_step_cnt !== 8'd0) begin errors++; $display("FAIL lim_cnt_clear got %0d exp 0", o_step_cnt); end
        @(negedge clk);
        for (int k = 1; k <= 4; k++) step((k == 4) ? 5'd24 : 5'd0);
        checks++; if ({o_episode_done, o_goal_reached} !== 2'b11) begin errors++; $display("FAIL lim_goal_last got %b exp 11", {o_episode_done, o_goal_reached}); end
        checks++; if (o_step_cnt !== 8'd4) begin errors++; $display("FAIL lim_goal_cnt got %0d exp 4", o_step_cnt); end
        checks++; if (o_episode_cnt !== 16'd2) begin errors++; $display("FAIL lim_ep_cnt got %0d exp 2", o_episode_cnt); end
        do_abort();
    endtask

    // Full run, 4 non-goal steps per episode; epsilon checked after each.
    task automatic test_epsilon_decay();
        logic [7:0] eps_now;
        i_first_st = 5'd0;
        start_run();
        @(negedge clk);
        for (int ep = 1; ep <= 120; ep++) begin
            eps_now = eps_after(ep - 1);
            for (int s = 1; s <= 4; s++) begin
                checks++; if (o_explore !== (lfsr_prev < eps_now)) begin errors++; $display("FAIL eps_explore ep %0d step %0d got %b exp %b", ep, s, o_explore, (lfsr_prev < eps_now)); end
                checks++; if (o_rand_at !== lfsr_prev[1:0]) begin errors++; $display("FAIL eps_rand_at ep %0d step %0d got %0d exp %0d", ep, s, o_rand_at, lfsr_prev[1:0]); end
                step(5'd1);
                if (s < 4) begin
                    checks++; if (o_step_req !== 1'b1) begin errors++; $display("FAIL eps_step_req ep %0d step %0d got %b exp 1", ep, s, o_step_req); end
                end
            end
            checks++; if ({o_episode_done, o_goal_reached} !== 2'b10) begin errors++; $display("FAIL eps_ep_done ep %0d got %b exp 10", ep, {o_episode_done, o_goal_reached}); end
            checks++; if (o_epsilon !== eps_after(ep)) begin errors++; $display("FAIL eps_value ep %0d got %0d exp %0d", ep, o_epsilon, eps_after(ep)); end
            checks++; if (o_episode_cnt !== 16'(ep)) begin errors++; $display("FAIL eps_ep_cnt got %0d exp %0d", o_episode_cnt, ep); end
            @(negedge clk);
            if (ep < 120) begin
                checks++; if ({o_start, o_busy, o_done} !== 3'b110) begin errors++; $display("FAIL eps_next ep %0d got %b exp 110", ep, {o_start, o_busy, o_done}); end
                @(negedge clk);
            end else begin
                checks++; if ({o_start, o_busy, o_done} !== 3'b001) begin errors++; $display("FAIL eps_done got %b exp 001", {o_start, o_busy, o_done}); end
            end
        end
        checks++; if (o_epsilon !== 8'd13) begin errors++; $display("FAIL eps_floor got %0d exp 13", o_epsilon); end
    endtask

    // Second full run started from DONE; episodes of 1..4 steps with the
    // goal on step (ep%5)+1, or no goal at all when that is 5.
    task automatic test_exploration();
        logic [7:0] eps_now;
        int g;
        bit fin;
        int explores;
        explores = 0;
        i_first_st = 5'd7;
        start_run();
        checks++; if ({o_start, o_done, o_busy} !== 3'b101) begin errors++; $display("FAIL expl_restart got %b exp 101", {o_start, o_done, o_busy}); end
        checks++; if (o_episode_cnt !== 16'd0) begin errors++; $display("FAIL expl_ep_cnt got %0d exp 0", o_episode_cnt); end
        checks++; if (o_epsilon !== 8'd230) begin errors++; $display("FAIL expl_eps got %0d exp 230", o_epsilon); end
        @(negedge clk);
        for (int ep = 1; ep <= 120; ep++) begin
            eps_now = eps_after(ep - 1);
            g = (ep % 5) + 1;
            fin = 1'b0;
            for (int s = 1; s <= 4 && !fin; s++) begin
                checks++; if (o_explore !== (lfsr_prev < eps_now)) begin errors++; $display("FAIL expl_explore ep %0d step %0d got %b exp %b", ep, s, o_explore, (lfsr_prev < eps_now)); end
                checks++; if (dut.lfsr === 8'd0) begin errors++; $display("FAIL expl_lfsr_zero got %h exp nonzero", dut.lfsr); end
                if (o_explore === 1'b1) explores++;
                step((s == g) ? 5'd24 : 5'd3);
                fin = (s == g) || (s == 4);
            end
            checks++; if ({o_episode_done, o_goal_reached} !== {1'b1, (g <= 4)}) begin errors++; $display("FAIL expl_ep_end ep %0d got %b exp %b", ep, {o_episode_done, o_goal_reached}, {1'b1, (g <= 4)}); end
            checks++; if (o_step_cnt !== 8'((g <= 4) ? g : 4)) begin errors++; $display("FAIL expl_step_cnt ep %0d got %0d exp %0d", ep, o_step_cnt, (g <= 4) ? g : 4); end
            @(negedge clk);
            if (ep < 120) @(negedge clk);
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL expl_done got %b exp 1", o_done); end
        checks++; if (explores == 0) begin errors++; $display("FAIL expl_rate got %0d explores exp nonzero", explores); end
    endtask

    task automatic test_abort_run();
        i_first_st = 5'd1;
        start_run();
        checks++; if ({o_start, o_done} !== 2'b10) begin errors++; $display("FAIL ab_start got %b exp 10", {o_start, o_done}); end
        @(negedge clk);
        step(5'd24);
        @(negedge clk);                 // START
        @(negedge clk);                 // STEP_REQ
        i_run = 1'b1;                   // run while busy
        @(negedge clk);                 // WAIT
        i_run = 1'b0;
        checks++; if ({o_start, o_busy} !== 2'b01) begin errors++; $display("FAIL ab_busy_run got %b exp 01", {o_start, o_busy}); end
        i_abort      = 1'b1;
        i_run        = 1'b1;
        i_step_valid = 1'b1;
        i_next_st    = 5'd24;
        @(negedge clk);
        i_abort      = 1'b0;
        i_run        = 1'b0;
        i_step_valid = 1'b0;
        checks++; if ({o_busy, o_done, o_start, o_episode_done} !== 4'b0) begin errors++; $display("FAIL ab_idle got %b exp 0000", {o_busy, o_done, o_start, o_episode_done}); end
        checks++; if (o_episode_cnt !== 16'd1) begin errors++; $display("FAIL ab_keep_cnt got %0d exp 1", o_episode_cnt); end
        checks++; if (o_epsilon !== 8'd228) begin errors++; $display("FAIL ab_keep_eps got %0d exp 228", o_epsilon); end
        @(negedge clk);
        checks++; if ({o_start, o_episode_done, o_busy, o_done} !== 4'b0) begin errors++; $display("FAIL ab_quiet got %b exp 0000", {o_start, o_episode_done, o_busy, o_done}); end
        start_run();
        checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL ab_rerun got %b exp 1", o_start); end
        checks++; if (o_episode_cnt !== 16'd0) begin errors++; $display("FAIL ab_rerun_cnt got %0d exp 0", o_episode_cnt); end
        checks++; if (o_epsilon !== 8'd230) begin errors++; $display("FAIL ab_rerun_eps got %0d exp 230", o_epsilon); end
        do_abort();
    endtask

    initial begin
        rst          = 1'b1;
        i_run        = 1'b0;
        i_abort      = 1'b0;
        i_first_st   = 5'd0;
        i_step_valid = 1'b0;
        i_next_st    = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_goal_path();
        test_step_limit();
        test_epsilon_decay();
        test_exploration();
        test_abort_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
